pixel_frame_arbiter: RTL and testbench
======================================

// Module: pixel_frame_arbiter
// PURPOSE
// - Shares the single RGB->32-bit AXI-Stream packer between two pixel sources (s0: camera, s1: CNN overlay).
// - Grants the packer for one whole frame at a time, round-robin, so frames never interleave.
// - Checks that every line is a multiple of 4 pixels, which the packer requires for tkeep=4'hf.
// - Sits directly upstream of the packer; m_* drives its r/g/b/valid/sof/eol and m_ready is its in_stream_ready.
// PARAMETERS
// FRAME_LINES  480  eol beats per frame; the frame ends on eol number FRAME_LINES
// CNT_W        16   width of the per-source completed-frame counters
// PORTS
// aclk          in   1      clock, all logic on rising edge
// areset        in   1      asynchronous reset, active-high
// en            in   1      1 = new grants allowed; 0 = the current frame finishes, then no new grant
// sN_rgb        in   24     source N pixel {r,g,b}, N=0,1
// sN_valid      in   1      source N pixel valid
// sN_sof        in   1      source N start of frame (first pixel)
// sN_eol        in   1      source N end of line (last pixel of line)
// sN_ready      out  1      source N beat accepted when sN_valid & sN_ready
// m_rgb         out  24     to packer {r,g,b}
// m_valid       out  1      to packer valid
// m_sof         out  1      to packer sof
// m_eol         out  1      to packer eol
// m_ready       in   1      packer in_stream_ready
// busy          out  1      1 = a frame is locked to a source
// grant_id      out  1      source that owns the packer; valid only while busy
// err_align     out  1      sticky: an eol arrived with (col+1) % 4 != 0
// err_sof       out  1      sticky: sof arrived on the granted source mid-frame
// err_clr       in   1      clears both sticky errors
// frames0/1     out  CNT_W  completed frames per source, wrap at 2^CNT_W
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; busy=0; grant_id=0; last=1, so s0 wins the first tie.
//   Also cleared: col, line, errors, frame counters. m_valid=0 and sN_ready=0 except for IDLE discard.
// - FSM has two states, IDLE and LOCKED.
// - IDLE:
//   - m_valid=0.
//   - A source with valid & ~sof is discarded (sN_ready=1). This flushes a partial frame.
//   - A source with valid & sof is held (sN_ready=0) and is a request.
//   - If en=1 and at least one request exists, go to LOCKED next cycle: grant_id = requester; on a tie, ~last.
//   - The held sof beat is forwarded in the first LOCKED cycle, so there is 1 bubble cycle per frame.
// - LOCKED:
//   - Combinational mux by the registered grant_id: m_* = s[grant]_*; s[grant]_ready = m_ready.
//   - Zero cycles of latency through the block.
//   - The other source gets sN_ready=0 and is stalled; its beats are never dropped while LOCKED.
// - Beat accounting on an accepted beat (m_valid & m_ready) only:
//   - Not eol: col++.
//   - eol: if col[1:0] != 2'b11 then err_align <= 1; col <= 0; line++.
//   - eol with line == FRAME_LINES-1: frames[grant]++, last <= grant_id, line <= 0, go to IDLE next cycle.
// - sof on an accepted beat with (col|line) != 0:
//   - err_sof <= 1 and counters restart with this beat as pixel 0 of line 0.
//   - The grant is kept and the beat is forwarded.
// - en falling mid-frame has no effect until the frame ends.
// - err_clr and a new error in the same cycle: the error wins and the flag stays 1.
// - Reset mid-frame: outputs go idle immediately. No flush is required; the packer restarts on the next sof.
// - col width is clog2 of the longest line (12 bits); line counter width is clog2(FRAME_LINES).
// STRUCTURE
// - Shared package video_stream_pkg:
//   - RGB_W=24 and PIX_PER_WORD=4.
//   - The arbiter state encoding (IDLE=1'b0, LOCKED=1'b1).
// - One sub-module, frame_position_counter:
//   - Contains col/line counters, the alignment check and the frame_done strobe.
//   - Reused by the future frame-timing generator.
// - The arbiter top holds the FSM, the round-robin pointer, the mux and the frame counters.
// TESTING (FRAME_LINES=2 in the bench)
// 1. Only s0 streams 2 lines of 8 px, m_ready=1.
//    -> 16 beats on m_*, one bubble after sof, frames0=1, busy drops the cycle after the 2nd eol.
// 2. s0 and s1 both present sof in the same cycle after reset.
//    -> s0 is granted first and s1 is stalled (s1_ready=0) for all 16 beats.
//    -> s1 is granted next; a 3rd contention grants s0 again.
// 3. m_ready toggles 1,0,1,0 during a frame.
//    -> s0_ready tracks m_ready each cycle, no beat is duplicated or lost, and m_rgb is stable while m_ready=0.
// 4. s1 sends eol after 6 px.
//    -> err_align=1; err_clr pulse -> 0; err_clr together with a new bad eol -> stays 1.
// 5. s0 sends sof at col=3 of line 1.
//    -> err_sof=1 and the frame restarts; 2 further lines are needed before frames0 increments.
// 6. s1 sends 5 px without sof in IDLE, then sof with en=0; then en=1.
//    -> the 5 px are discarded (s1_ready=1) with m_valid=0; no grant while en=0; grant follows en=1.
//    -> areset asserted mid-frame: busy=0 and m_valid=0 immediately.

Source files
------------

// File: rtl/video_stream_pkg.sv
// Shared video-stream definitions: pixel width, packer word geometry,
// arbiter state encoding and the debug view of the arbiter.
package video_stream_pkg;

    localparam int RGB_W        = 24;
    localparam int PIX_PER_WORD = 4;

    // Longest supported line is 4096 pixels, so the column counter is 12 bits.
    localparam int MAX_LINE_PIX = 4096;
    localparam int COL_W        = $clog2(MAX_LINE_PIX);

    // Line number as seen on the debug port, zero-extended.
    localparam int DBG_LINE_W = 16;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        arb_state_t            state;
        logic [COL_W-1:0]      col;
        logic [DBG_LINE_W-1:0] line;
    } arb_dbg_t;

    // Width of a line counter for a frame of 'lines' lines (at least 1 bit).
    function automatic int line_cnt_w(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

endpackage

// File: rtl/frame_position_counter.sv
// Tracks column/line position inside a frame from accepted beats, flags
// lines whose length is not a whole number of packer words, flags a sof
// seen away from pixel 0, and strobes frame_done on the final eol.
module frame_position_counter
    import video_stream_pkg::*;
#(
    parameter int FRAME_LINES = 480,
    parameter int LINE_W      = line_cnt_w(FRAME_LINES)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              beat,
    input  logic              sof,
    input  logic              eol,
    output logic [COL_W-1:0]  col,
    output logic [LINE_W-1:0] line,
    output logic              align_err,
    output logic              sof_err,
    output logic              frame_done
);

    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(FRAME_LINES - 1);
    localparam logic [1:0]        WORD_LAST = 2'(PIX_PER_WORD - 1);

    logic              restart;
    logic [COL_W-1:0]  eff_col;
    logic [LINE_W-1:0] eff_line;

    // A mid-frame sof makes this beat pixel 0 of line 0; everything else uses the effective position.
    always_comb begin
        restart    = beat & sof & ((col != '0) | (line != '0));
        eff_col    = restart ? '0 : col;
        eff_line   = restart ? '0 : line;
        sof_err    = restart;
        align_err  = beat & eol & (eff_col[1:0] != WORD_LAST);
        frame_done = beat & eol & (eff_line == LAST_LINE);
    end

    // Position registers advance only on accepted beats.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            col  <= '0;
            line <= '0;
        end else if (beat) begin
            if (eol) begin
                col  <= '0;
                line <= (eff_line == LAST_LINE) ? '0 : eff_line + LINE_W'(1);
            end else begin
                col  <= eff_col + COL_W'(1);
                line <= eff_line;
            end
        end
    end

endmodule

// File: rtl/pixel_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the RGB->AXI-Stream packer.
// One source owns the packer from its sof until the last eol of the frame;
// the other source is back-pressured, never dropped, meanwhile.
//
// Handshake: every stream beat transfers on a rising edge where valid and
// ready are both 1; valid/data are held by the sender until then, and ready
// may change freely. In LOCKED the owner's ready is the packer's m_ready
// (pure combinational path). In IDLE a non-sof beat is accepted and dropped,
// while a sof beat is held as a request and forwarded once the grant lands.
module pixel_frame_arbiter
    import video_stream_pkg::*;
#(
    parameter int FRAME_LINES = 480,
    parameter int CNT_W       = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             en,
    input  logic [RGB_W-1:0] s0_rgb,
    input  logic             s0_valid,
    input  logic             s0_sof,
    input  logic             s0_eol,
    output logic             s0_ready,
    input  logic [RGB_W-1:0] s1_rgb,
    input  logic             s1_valid,
    input  logic             s1_sof,
    input  logic             s1_eol,
    output logic             s1_ready,
    output logic [RGB_W-1:0] m_rgb,
    output logic             m_valid,
    output logic             m_sof,
    output logic             m_eol,
    input  logic             m_ready,
    output logic             busy,
    output logic             grant_id,
    output logic             err_align,
    output logic             err_sof,
    input  logic             err_clr,
    output logic [CNT_W-1:0] frames0,
    output logic [CNT_W-1:0] frames1,
    output arb_dbg_t         dbg
);

    localparam int LINE_W = line_cnt_w(FRAME_LINES);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              grant_nxt;
    logic              last;
    logic              req0;
    logic              req1;
    logic              beat;
    logic              align_err;
    logic              sof_err;
    logic              frame_done;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;

    assign req0 = s0_valid & s0_sof;
    assign req1 = s1_valid & s1_sof;
    assign beat = m_valid & m_ready;

    frame_position_counter #(
        .FRAME_LINES (FRAME_LINES),
        .LINE_W      (LINE_W)
    ) u_pos (
        .aclk       (aclk),
        .areset     (areset),
        .beat       (beat),
        .sof        (m_sof),
        .eol        (m_eol),
        .col        (col),
        .line       (line),
        .align_err  (align_err),
        .sof_err    (sof_err),
        .frame_done (frame_done)
    );

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next grant: grant on a pending sof, release on the last eol.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        case (state)
            ARB_IDLE: begin
                if (en && (req0 || req1)) begin
                    state_nxt = ARB_LOCKED;
                    grant_nxt = (req0 && req1) ? ~last : req1;
                end
            end
            ARB_LOCKED: begin
                if (frame_done) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs: IDLE discards non-sof beats, LOCKED muxes the owner straight through.
    always_comb begin
        m_rgb    = '0;
        m_valid  = 1'b0;
        m_sof    = 1'b0;
        m_eol    = 1'b0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        case (state)
            ARB_IDLE: begin
                s0_ready = s0_valid & ~s0_sof;
                s1_ready = s1_valid & ~s1_sof;
            end
            ARB_LOCKED: begin
                if (grant_id) begin
                    m_rgb    = s1_rgb;
                    m_valid  = s1_valid;
                    m_sof    = s1_sof;
                    m_eol    = s1_eol;
                    s1_ready = m_ready;
                end else begin
                    m_rgb    = s0_rgb;
                    m_valid  = s0_valid;
                    m_sof    = s0_sof;
                    m_eol    = s0_eol;
                    s0_ready = m_ready;
                end
            end
            default: ;
        endcase
    end

    // Grant, round-robin pointer and per-source completed-frame counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            grant_id <= 1'b0;
            last     <= 1'b1;
            frames0  <= '0;
            frames1  <= '0;
        end else begin
            grant_id <= grant_nxt;
            if (frame_done) begin
                last <= grant_id;
                if (grant_id) begin
                    frames1 <= frames1 + CNT_W'(1);
                end else begin
                    frames0 <= frames0 + CNT_W'(1);
                end
            end
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_align <= 1'b0;
            err_sof   <= 1'b0;
        end else begin
            err_align <= align_err | (err_align & ~err_clr);
            err_sof   <= sof_err | (err_sof & ~err_clr);
        end
    end

    assign busy      = (state == ARB_LOCKED);
    assign dbg.state = state;
    assign dbg.col   = col;
    assign dbg.line  = DBG_LINE_W'(line);

endmodule

// File: tb/tb_pixel_frame_arbiter.sv
// Directed and randomized bench for pixel_frame_arbiter with FRAME_LINES=2.
// Expected beats come from frame lists ordered by a round-robin model.
module tb_pixel_frame_arbiter;
    import video_stream_pkg::*;

    localparam int FRAME_LINES = 2;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 2000;

    logic             aclk = 1'b0;
    logic             areset;
    logic             en;
    logic             err_clr;
    logic             m_ready;
    logic [23:0]      s_rgb [2];
    logic [1:0]       s_valid;
    logic [1:0]       s_sof;
    logic [1:0]       s_eol;
    logic [1:0]       s_ready;
    logic [23:0]      m_rgb;
    logic             m_valid;
    logic             m_sof;
    logic             m_eol;
    logic             busy;
    logic             grant_id;
    logic             err_align;
    logic             err_sof;
    logic [CNT_W-1:0] frames0;
    logic [CNT_W-1:0] frames1;
    arb_dbg_t         dbg;

    pixel_frame_arbiter #(
        .FRAME_LINES (FRAME_LINES),
        .CNT_W       (CNT_W)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .en        (en),
        .s0_rgb    (s_rgb[0]),
        .s0_valid  (s_valid[0]),
        .s0_sof    (s_sof[0]),
        .s0_eol    (s_eol[0]),
        .s0_ready  (s_ready[0]),
        .s1_rgb    (s_rgb[1]),
        .s1_valid  (s_valid[1]),
        .s1_sof    (s_sof[1]),
        .s1_eol    (s_eol[1]),
        .s1_ready  (s_ready[1]),
        .m_rgb     (m_rgb),
        .m_valid   (m_valid),
        .m_sof     (m_sof),
        .m_eol     (m_eol),
        .m_ready   (m_ready),
        .busy      (busy),
        .grant_id  (grant_id),
        .err_align (err_align),
        .err_sof   (err_sof),
        .err_clr   (err_clr),
        .frames0   (frames0),
        .frames1   (frames1),
        .dbg       (dbg)
    );

    // ---------------- clock ----------------
    always #5 aclk = ~aclk;

    // ---------------- scoreboard / model state ----------------
    int          errors = 0;
    int          checks = 0;
    int          beat_cnt = 0;
    int          next_tag = 1;
    int          model_frames [2];
    bit          model_last;
    bit          gap_en = 1'b0;
    int          mready_mode = 0;   // 0 hold, 1 toggle, 2 random
    logic [25:0] exp_q [$];         // {sof, eol, rgb} in packer order
    logic [25:0] q0 [$];
    logic [25:0] q1 [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: on a tie the source that did not own the previous frame wins.
    function automatic bit rr_pick(input bit want0, input bit want1);
        if (want0 && want1) return ~model_last;
        return want1;
    endfunction

    // ---------------- stimulus builders ----------------
    task automatic add_line(input int src, input int tag, input int ln, input int len,
                            input bit sof_first, input bit eol_last);
        logic [25:0] b;
        for (int c = 0; c < len; c++) begin
            b[23:0] = {src[0], tag[6:0], ln[7:0], c[7:0]};
            b[25]   = sof_first && (c == 0);
            b[24]   = eol_last && (c == len - 1);
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic add_frame(input int src, input int l0, input int l1);
        int tag;
        tag = next_tag;
        next_tag++;
        add_line(src, tag, 0, l0, 1'b1, 1'b1);
        for (int ln = 1; ln < FRAME_LINES; ln++) add_line(src, tag, ln, l1, 1'b0, 1'b1);
        model_frames[src]++;
        model_last = src[0];
    endtask

    // Both sources keep requesting; the model decides the packer order frame by frame.
    task automatic queue_frames(input int n0, input int n1, input bit rand_len);
        int r0, r1;
        bit pick;
        r0 = n0;
        r1 = n1;
        while (r0 > 0 || r1 > 0) begin
            pick = rr_pick(r0 > 0, r1 > 0);
            if (rand_len) add_frame(pick, 4 * $urandom_range(1, 3), 4 * $urandom_range(1, 3));
            else          add_frame(pick, 8, 8);
            if (pick) r1--;
            else      r0--;
        end
    endtask

    // ---------------- driver tasks (entered and left #1 after a rising edge) ----------------
    task automatic send_beat(input int src, input logic [25:0] b, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        s_rgb[src]   = b[23:0];
        s_sof[src]   = b[25];
        s_eol[src]   = b[24];
        s_valid[src] = 1'b1;
        while (n < TIMEOUT) begin
            @(negedge aclk);
            if (s_ready[src] === 1'b1) ok = 1'b1;
            @(posedge aclk);
            #1;
            if (ok) break;
            n++;
        end
        s_valid[src] = 1'b0;
        s_sof[src]   = 1'b0;
        s_eol[src]   = 1'b0;
        check($sformatf("s%0d_accept", src), ok, 1'b1);
    endtask

    task automatic send_all(input int src);
        logic [25:0] b;
        bit ok;
        int n;
        forever begin
            if (src == 0) begin
                if (q0.size() == 0) break;
                b = q0.pop_front();
            end else begin
                if (q1.size() == 0) break;
                b = q1.pop_front();
            end
            if (gap_en && !b[25]) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    @(posedge aclk);
                    #1;
                end
            end
            send_beat(src, b, ok);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge aclk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        exp_q.delete();
        model_last      = 1'b1;
        model_frames[0] = 0;
        model_frames[1] = 0;
    endtask

    task automatic do_reset();
        areset  = 1'b1;
        en      = 1'b1;
        err_clr = 1'b0;
        s_valid = '0;
        s_sof   = '0;
        s_eol   = '0;
        clear_model();
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    // ---------------- packer-side ready generator ----------------
    initial begin
        forever begin
            @(posedge aclk);
            #2;
            if (mready_mode == 1)      m_ready = ~m_ready;
            else if (mready_mode == 2) m_ready = ($urandom_range(0, 9) < 7);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        owner;
        logic        prev_stall;
        logic [25:0] prev_beat;
        logic [25:0] exp_b;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge aclk);
            if (areset !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                if (!busy) begin
                    check("idle_m_valid", m_valid, 1'b0);
                end else if (exp_q.size() != 0) begin
                    owner = exp_q[0][23];
                    check("grant_owner", grant_id, owner);
                    check("m_valid_mux", m_valid, s_valid[owner]);
                    check("owner_ready", s_ready[owner], m_ready);
                    check("other_ready", s_ready[~owner], 1'b0);
                end
                if (prev_stall) check("stall_hold", {m_sof, m_eol, m_rgb}, prev_beat);
                if (m_valid && m_ready) begin
                    beat_cnt++;
                    check("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check("beat_data", {m_sof, m_eol, m_rgb}, exp_b);
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_beat  = {m_sof, m_eol, m_rgb};
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [25:0] b;
        bit          ok;
        bit          found;
        int          bc0;
        int          tag;
        int          f0;

        areset  = 1'b1;
        en      = 1'b1;
        err_clr = 1'b0;
        m_ready = 1'b1;
        s_valid = '0;
        s_sof   = '0;
        s_eol   = '0;
        s_rgb[0] = '0;
        s_rgb[1] = '0;
        clear_model();
        @(posedge aclk);
        #1;

        // Reset state.
        check("rst_busy", busy, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_grant_id", grant_id, 1'b0);
        check("rst_frames0", frames0, '0);
        check("rst_frames1", frames1, '0);
        check("rst_err_align", err_align, 1'b0);
        check("rst_err_sof", err_sof, 1'b0);
        check("rst_s_ready", s_ready, 2'b00);
        check("rst_dbg", dbg, '0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // 1: s0 alone, 2 lines of 8 px, one bubble before the sof is forwarded.
        bc0 = beat_cnt;
        add_frame(0, 8, 8);
        fork
            send_all(0);
            begin
                @(negedge aclk);
                check("t1_bubble_busy", busy, 1'b0);
                check("t1_bubble_valid", m_valid, 1'b0);
                check("t1_bubble_ready", s_ready[0], 1'b0);
                @(negedge aclk);
                check("t1_fwd_busy", busy, 1'b1);
                check("t1_fwd_valid", m_valid, 1'b1);
                check("t1_fwd_sof", m_sof, 1'b1);
            end
        join
        @(negedge aclk);
        check("t1_busy_drop", busy, 1'b0);
        check("t1_frames0", frames0, CNT_W'(model_frames[0]));
        check("t1_beats", beat_cnt - bc0, 16);
        check("t1_drained", exp_q.size(), 0);
        @(posedge aclk);
        #1;

        // 2: simultaneous sof after reset, then a third contention.
        do_reset();
        queue_frames(1, 1, 1'b0);
        fork
            send_all(0);
            send_all(1);
        join
        @(negedge aclk);
        check("t2_frames0", frames0, CNT_W'(model_frames[0]));
        check("t2_frames1", frames1, CNT_W'(model_frames[1]));
        check("t2_drained", exp_q.size(), 0);
        @(posedge aclk);
        #1;
        queue_frames(1, 1, 1'b0);
        fork
            send_all(0);
            send_all(1);
        join
        @(negedge aclk);
        check("t2c_frames0", frames0, CNT_W'(model_frames[0]));
        check("t2c_frames1", frames1, CNT_W'(model_frames[1]));
        check("t2c_drained", exp_q.size(), 0);
        @(posedge aclk);
        #1;

        // 3: m_ready toggling every cycle during an s0 frame.
        bc0 = beat_cnt;
        add_frame(0, 8, 8);
        mready_mode = 1;
        send_all(0);
        mready_mode = 0;
        m_ready = 1'b1;
        @(negedge aclk);
        check("t3_beats", beat_cnt - bc0, 16);
        check("t3_frames0", frames0, CNT_W'(model_frames[0]));
        check("t3_drained", exp_q.size(), 0);
        @(posedge aclk);
        #1;

        // 4: s1 ends line 0 after 6 px.
        add_frame(1, 6, 8);
        send_all(1);
        @(negedge aclk);
        check("t4_err_align", err_align, 1'b1);
        check("t4_err_sof", err_sof, 1'b0);
        check("t4_frames1", frames1, CNT_W'(model_frames[1]));
        @(posedge aclk);
        #1;
        pulse_clr();
        @(negedge aclk);
        check("t4_cleared", err_align, 1'b0);
        @(posedge aclk);
        #1;
        add_frame(1, 6, 8);
        found = 1'b0;
        fork
            send_all(1);
            begin
                for (int n = 0; n < TIMEOUT; n++) begin
                    @(negedge aclk);
                    if (m_valid && m_ready && m_eol) begin
                        found = 1'b1;
                        break;
                    end
                end
                err_clr = 1'b1;
                @(posedge aclk);
                #1;
                err_clr = 1'b0;
            end
        join
        @(negedge aclk);
        check("t4_bad_eol_seen", found, 1'b1);
        check("t4_clr_vs_err", err_align, 1'b1);
        @(posedge aclk);
        #1;

        // 5: sof at col 3 of line 1 restarts the frame.
        pulse_clr();
        @(negedge aclk);
        check("t5_pre_align", err_align, 1'b0);
        check("t5_pre_sof", err_sof, 1'b0);
        @(posedge aclk);
        #1;
        f0  = model_frames[0];
        tag = next_tag;
        next_tag++;
        add_line(0, tag, 0, 8, 1'b1, 1'b1);
        add_line(0, tag, 1, 3, 1'b0, 1'b0);
        tag = next_tag;
        next_tag++;
        add_line(0, tag, 0, 8, 1'b1, 1'b1);
        send_all(0);
        @(negedge aclk);
        check("t5_err_sof", err_sof, 1'b1);
        check("t5_still_busy", busy, 1'b1);
        check("t5_no_frame_yet", frames0, CNT_W'(f0));
        @(posedge aclk);
        #1;
        add_line(0, tag, 1, 8, 1'b0, 1'b1);
        send_all(0);
        model_frames[0]++;
        model_last = 1'b0;
        @(negedge aclk);
        check("t5_frames0", frames0, CNT_W'(model_frames[0]));
        check("t5_busy_drop", busy, 1'b0);
        check("t5_err_align", err_align, 1'b0);
        @(posedge aclk);
        #1;

        // 6: discard in IDLE, hold with en=0, grant on en=1, reset mid-frame.
        bc0 = beat_cnt;
        for (int i = 0; i < 5; i++) begin
            b = {2'b00, 1'b1, 7'd99, 8'd0, 8'(i)};
            send_beat(1, b, ok);
        end
        check("t6_discard_no_out", beat_cnt - bc0, 0);
        en  = 1'b0;
        tag = next_tag;
        next_tag++;
        add_line(1, tag, 0, 8, 1'b1, 1'b1);
        s_rgb[1]   = q1[0][23:0];
        s_sof[1]   = 1'b1;
        s_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("t6_hold_busy", busy, 1'b0);
            check("t6_hold_ready", s_ready[1], 1'b0);
            @(posedge aclk);
            #1;
        end
        en = 1'b1;
        fork
            send_all(1);
            begin
                @(negedge aclk);
                check("t6_en_bubble", busy, 1'b0);
                @(negedge aclk);
                check("t6_grant_busy", busy, 1'b1);
                check("t6_grant_id", grant_id, 1'b1);
            end
        join
        s_rgb[1]   = 24'h8a0100;
        s_sof[1]   = 1'b0;
        s_eol[1]   = 1'b0;
        s_valid[1] = 1'b1;
        #1;
        areset = 1'b1;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_m_valid", m_valid, 1'b0);
        check("t6_rst_frames1", frames1, '0);
        check("t6_rst_err_sof", err_sof, 1'b0);
        s_valid[1] = 1'b0;
        clear_model();
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Random phase: both sources stream random-length frames with gaps and random m_ready.
        do_reset();
        gap_en      = 1'b1;
        mready_mode = 2;
        queue_frames(4, 4, 1'b1);
        fork
            send_all(0);
            send_all(1);
        join
        mready_mode = 0;
        m_ready     = 1'b1;
        gap_en      = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge aclk);
        check("rnd_frames0", frames0, CNT_W'(model_frames[0]));
        check("rnd_frames1", frames1, CNT_W'(model_frames[1]));
        check("rnd_drained", exp_q.size(), 0);
        check("rnd_err_align", err_align, 1'b0);
        check("rnd_err_sof", err_sof, 1'b0);
        check("rnd_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
